nabp_shifter_lut_arbiter: RTL



---
 rtl/nabp_lut_arb_pkg.sv | 12 +
 rtl/nabp_rr_picker.sv | 31 +++
 rtl/nabp_shifter_lut_arbiter.sv | 84 ++++++++
 3 files changed

// File: rtl/nabp_lut_arb_pkg.sv
// rtl/nabp_lut_arb_pkg.sv - shared defaults and lane typedefs for the shifter LUT arbiter
package nabp_lut_arb_pkg;

   localparam int kDefNumLanes    = 4;
   localparam int kDefAngleLength = 9;
   localparam int kDefAccuWidth   = 16;
   localparam int kDefIdxWidth    = (kDefNumLanes > 1) ? $clog2(kDefNumLanes) : 1;

   typedef logic [kDefIdxWidth-1:0] lane_idx_t;
   typedef logic [kDefNumLanes-1:0] lane_mask_t;

endpackage

// File: rtl/nabp_rr_picker.sv
// rtl/nabp_rr_picker.sv - combinational round-robin winner search from rr_ptr upward
module nabp_rr_picker
   import nabp_lut_arb_pkg::*;
#(
   parameter int kNumLanes = kDefNumLanes,
   parameter int kIdxW     = kDefIdxWidth
) (
   input  logic [kNumLanes-1:0] req_valid,
   input  logic [kIdxW-1:0]     rr_ptr,
   output logic [kNumLanes-1:0] winner_onehot,
   output logic [kIdxW-1:0]     winner_idx,
   output logic                 winner_found
);

   always_comb begin
      int idx;
      winner_onehot = '0;
      winner_idx    = '0;
      winner_found  = 1'b0;
      idx           = 0;
      for (int k = 0; k < kNumLanes; k++) begin
         idx = (int'(rr_ptr) + k) % kNumLanes;
         if (!winner_found && req_valid[idx]) begin
            winner_found       = 1'b1;
            winner_onehot[idx] = 1'b1;
            winner_idx         = kIdxW'(idx);
         end
      end
   end

endmodule

// File: rtl/nabp_shifter_lut_arbiter.sv
// rtl/nabp_shifter_lut_arbiter.sv - round-robin sharing of one registered angle LUT between lanes
// Macro NABP_LUT_ARB_COALESCE_EN: equal-angle lanes are granted together with the winner.
module nabp_shifter_lut_arbiter
   import nabp_lut_arb_pkg::*;
#(
   parameter int kNumLanes    = kDefNumLanes,
   parameter int kAngleLength = kDefAngleLength,
   parameter int kAccuWidth   = kDefAccuWidth
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic [kNumLanes-1:0]              req_valid,
   input  logic [kNumLanes*kAngleLength-1:0] req_angle,
   output logic [kNumLanes-1:0]              req_ready,
   output logic [kAngleLength-1:0]           lut_angle,
   input  logic [kAccuWidth-1:0]             lut_accu_base,
   output logic [kNumLanes-1:0]              resp_valid,
   output logic [kAccuWidth-1:0]             resp_accu_base,
   output logic                              busy
);

   localparam int kIdxW = (kNumLanes > 1) ? $clog2(kNumLanes) : 1;

   logic [kIdxW-1:0]        rr_ptr;
   logic [kIdxW-1:0]        win_idx;
   logic [kIdxW-1:0]        next_ptr;
   logic                    win_found;
   logic [kNumLanes-1:0]    win_onehot;
   logic [kNumLanes-1:0]    grant;
   logic [kNumLanes-1:0]    s1_mask;
   logic [kNumLanes-1:0]    s2_mask;
   logic [kAngleLength-1:0] win_angle;

   nabp_rr_picker #(
      .kNumLanes (kNumLanes),
      .kIdxW     (kIdxW)
   ) u_picker (
      .req_valid     (req_valid),
      .rr_ptr        (rr_ptr),
      .winner_onehot (win_onehot),
      .winner_idx    (win_idx),
      .winner_found  (win_found)
   );

   assign win_angle = req_angle[int'(win_idx)*kAngleLength +: kAngleLength];
   assign next_ptr  = (int'(win_idx) == kNumLanes - 1) ? '0 : win_idx + 1'b1;

`ifdef NABP_LUT_ARB_COALESCE_EN
   // Lanes asking for the winner's angle ride along on the same lookup.
   always_comb begin
      grant = '0;
      for (int i = 0; i < kNumLanes; i++) begin
         grant[i] = win_onehot[i] |
                    (win_found && req_valid[i] &&
                     (req_angle[i*kAngleLength +: kAngleLength] == win_angle));
      end
   end
`else
   assign grant = win_onehot;
`endif

   assign req_ready = reset ? '0 : grant;

   always_ff @(posedge clk) begin
      if (reset) begin
         rr_ptr    <= '0;
         lut_angle <= '0;
         s1_mask   <= '0;
         s2_mask   <= '0;
      end else begin
         if (win_found) begin
            rr_ptr    <= next_ptr;
            lut_angle <= win_angle;
         end
         s1_mask <= grant;
         s2_mask <= s1_mask;
      end
   end

   assign resp_valid     = s2_mask;
   assign resp_accu_base = lut_accu_base;
   assign busy           = (|s1_mask) | (|s2_mask);

endmodule
